// File: rtl/lcd_grid_pkg.sv
// lcd_grid_pkg: LCD command bytes, RGB565 palette, grid-line colour and FSM state type
// shared by lcd_grid_streamer and lcd_spi_byte_tx.
package lcd_grid_pkg;
    localparam logic [7:0] SLPOUT = 8'h11;
    localparam logic [7:0] COLMOD = 8'h3A;
    localparam logic [7:0] MADCTL = 8'h36;
    localparam logic [7:0] DISPON = 8'h29;
    localparam logic [7:0] CASET  = 8'h2A;
    localparam logic [7:0] RASET  = 8'h2B;
    localparam logic [7:0] RAMWR  = 8'h2C;
    localparam logic [15:0] GRID_COLOUR = 16'h8410;
    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
        16'h8410, 16'hFC00, 16'h8000, 16'h0400, 16'h0010, 16'h8010, 16'h0410, 16'hC618
    };
    typedef enum logic [2:0] {
        ST_RST_LOW, ST_RST_WAIT, ST_SLPOUT, ST_SLP_WAIT, ST_INIT, ST_IDLE, ST_WINDOW, ST_STREAM
    } state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // {dc, byte} for the post-SLPOUT init sequence: COLMOD 0x55, MADCTL 0x00, DISPON
    function automatic logic [8:0] init_byte(input logic [3:0] i);
        return (i == 4'd0) ? {1'b0, COLMOD} : (i == 4'd1) ? {1'b1, 8'h55} :
               (i == 4'd2) ? {1'b0, MADCTL} : (i == 4'd3) ? {1'b1, 8'h00} : {1'b0, DISPON};
    endfunction
endpackage

// File: rtl/lcd_spi_byte_tx.sv
// lcd_spi_byte_tx: sends one byte MSB first on SPI mode 0 framed by CS; o_done pulses on the
// last clk of the byte. Accepts i_start only while idle.
module lcd_spi_byte_tx
    import lcd_grid_pkg::*;
#(
    parameter int CLK_DIV = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_dc,
    output logic       o_done,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_dc
);
    localparam int DW = cnt_w(CLK_DIV);
    logic          r_act;
    logic          r_dc;
    logic [4:0]    r_hp;
    logic [DW-1:0] r_div;
    logic [7:0]    r_sh;
    logic          w_tick;
    assign w_tick = r_div == DW'(CLK_DIV - 1);
    // Half-period 0 is CS setup, odd ones are SCK high, 16 is the last low, 17 is CS high.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_act <= 1'b0;
            r_dc  <= 1'b0;
            r_hp  <= '0;
            r_div <= '0;
            r_sh  <= '0;
        end else if (!r_act) begin
            if (i_start) begin
                r_act <= 1'b1;
                r_hp  <= '0;
                r_div <= '0;
                r_sh  <= i_byte;
                r_dc  <= i_dc;
            end
        end else if (w_tick) begin
            r_div <= '0;
            r_hp  <= r_hp + 5'd1;
            if (r_hp[0]) r_sh <= {r_sh[6:0], 1'b0};
            if (r_hp == 5'd17) r_act <= 1'b0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    assign o_done = r_act && w_tick && r_hp == 5'd17;
    assign o_cs_n = !(r_act && r_hp != 5'd17);
    assign o_sck  = r_act && r_hp[0] && r_hp != 5'd17;
    assign o_mosi = r_act ? r_sh[7] : 1'b0;
    assign o_dc   = r_dc;
endmodule

// File: rtl/lcd_grid_streamer.sv
// lcd_grid_streamer: resets/initialises an RGB565 SPI LCD, then streams one frame per accepted
// grid snapshot. Define GRID_LINES_EN to draw 1-px cell borders on each cell's top/left edge.
module lcd_grid_streamer
    import lcd_grid_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int CELL_W   = 5,
    parameter int CELL_PX  = 30,
    parameter int CLK_DIV  = 2,
    parameter int RST_HOLD = 2000,
    parameter int RST_WAIT = 2000
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROWS*COLS*CELL_W-1:0] grid_in,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    output logic                        busy,
    output logic                        lcd_rst_n_out,
    output logic                        lcd_bl_out,
    output logic                        lcd_dc_out,
    output logic                        lcd_clk_out,
    output logic                        lcd_data_out,
    output logic                        lcd_cs_n_out
);
    localparam int PXW = cnt_w(CELL_PX);
    localparam int CXW = cnt_w(COLS);
    localparam int CYW = cnt_w(ROWS);
    localparam logic [15:0] W1 = 16'(COLS * CELL_PX - 1);
    localparam logic [15:0] H1 = 16'(ROWS * CELL_PX - 1);
    state_t                      r_state, w_next;
    logic [31:0]                 r_cnt;
    logic [3:0]                  r_idx;
    logic [ROWS*COLS*CELL_W-1:0] r_grid;
    logic [PXW-1:0]              r_px, r_py;
    logic [CXW-1:0]              r_cx;
    logic [CYW-1:0]              r_cy;
    logic                        r_hi;
    logic                        w_start, w_done, w_dc, w_last, w_unused;
    logic                        w_px_end, w_cx_end, w_py_end, w_cy_end;
    logic [7:0]                  w_byte;
    logic [8:0]                  w_win;
    logic [CELL_W-1:0]           w_code;
    logic [15:0]                 w_colour;
    assign w_px_end = r_px == PXW'(CELL_PX - 1);
    assign w_cx_end = r_cx == CXW'(COLS - 1);
    assign w_py_end = r_py == PXW'(CELL_PX - 1);
    assign w_cy_end = r_cy == CYW'(ROWS - 1);
    assign w_last   = w_px_end && w_cx_end && w_py_end && w_cy_end;
    assign w_code   = r_grid[(int'(r_cy) * COLS + int'(r_cx)) * CELL_W +: CELL_W];
    assign w_unused = ^w_code;
`ifdef GRID_LINES_EN
    assign w_colour = (r_px == '0 || r_py == '0) ? GRID_COLOUR : PALETTE[w_code[3:0]];
`else
    assign w_colour = PALETTE[w_code[3:0]];
`endif
    assign w_win = (r_idx == 4'd0) ? {1'b0, CASET} : (r_idx == 4'd3) ? {1'b1, W1[15:8]} :
                   (r_idx == 4'd4) ? {1'b1, W1[7:0]} : (r_idx == 4'd5) ? {1'b0, RASET} :
                   (r_idx == 4'd8) ? {1'b1, H1[15:8]} : (r_idx == 4'd9) ? {1'b1, H1[7:0]} :
                   (r_idx == 4'd10) ? {1'b0, RAMWR} : {1'b1, 8'h00};
    assign w_start = r_state inside {ST_SLPOUT, ST_INIT, ST_WINDOW, ST_STREAM};
    assign {w_dc, w_byte} = (r_state == ST_SLPOUT) ? {1'b0, SLPOUT} :
                            (r_state == ST_INIT)   ? init_byte(r_idx) :
                            (r_state == ST_WINDOW) ? w_win :
                            {1'b1, r_hi ? w_colour[15:8] : w_colour[7:0]};
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST_LOW:  if (r_cnt == 32'(RST_HOLD - 1)) w_next = ST_RST_WAIT;
            ST_RST_WAIT: if (r_cnt == 32'(RST_WAIT - 1)) w_next = ST_SLPOUT;
            ST_SLPOUT:   if (w_done) w_next = ST_SLP_WAIT;
            ST_SLP_WAIT: if (r_cnt == 32'(RST_WAIT - 1)) w_next = ST_INIT;
            ST_INIT:     if (w_done && r_idx == 4'd4) w_next = ST_IDLE;
            ST_IDLE:     if (frame_valid) w_next = ST_WINDOW;
            ST_WINDOW:   if (w_done && r_idx == 4'd10) w_next = ST_STREAM;
            ST_STREAM:   if (w_done && !r_hi && w_last) w_next = ST_IDLE;
            default:     w_next = ST_RST_LOW;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= ST_RST_LOW;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_grid  <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_hi    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
            r_idx   <= (w_next != r_state) ? '0 : r_idx + 4'(w_done);
            if (r_state == ST_IDLE && frame_valid) r_grid <= grid_in;
            if (r_state == ST_WINDOW) begin
                r_px <= '0;
                r_py <= '0;
                r_cx <= '0;
                r_cy <= '0;
                r_hi <= 1'b1;
            end else if (r_state == ST_STREAM && w_done) begin
                // Counters step only after the low byte, so the colour is stable across both bytes.
                r_hi <= !r_hi;
                if (!r_hi) begin
                    r_px <= w_px_end ? '0 : r_px + PXW'(1);
                    if (w_px_end) r_cx <= w_cx_end ? '0 : r_cx + CXW'(1);
                    if (w_px_end && w_cx_end) r_py <= w_py_end ? '0 : r_py + PXW'(1);
                    if (w_px_end && w_cx_end && w_py_end) r_cy <= w_cy_end ? '0 : r_cy + CYW'(1);
                end
            end
        end
    assign frame_ready   = r_state == ST_IDLE;
    assign busy          = !frame_ready;
    assign lcd_rst_n_out = r_state != ST_RST_LOW;
    assign lcd_bl_out    = r_state inside {ST_IDLE, ST_WINDOW, ST_STREAM};
    lcd_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_byte (w_byte),
        .i_dc   (w_dc),
        .o_done (w_done),
        .o_sck  (lcd_clk_out),
        .o_mosi (lcd_data_out),
        .o_cs_n (lcd_cs_n_out),
        .o_dc   (lcd_dc_out)
    );
endmodule

// File: tb/tb_lcd_grid_streamer.sv
// tb_lcd_grid_streamer: decodes the SPI byte stream and compares it with a frame model built
// from the grid snapshot, plus literal pins on init, window and selected pixels.
module tb_lcd_grid_streamer;
    localparam int ROWS = 2, COLS = 2, CELL_W = 5, PX = 2;
    localparam int W = COLS * PX, H = ROWS * PX;
`ifdef GRID_LINES_EN
    localparam logic [8:0] P2H = 9'h184, P2L = 9'h110, P8H = 9'h184, P8L = 9'h110;
    localparam logic [8:0] F0H = 9'h184, F0L = 9'h110;
`else
    localparam logic [8:0] P2H = 9'h1F8, P2L = 9'h100, P8H = 9'h107, P8L = 9'h1E0;
    localparam logic [8:0] F0H = 9'h1C6, F0L = 9'h118;
`endif
    logic clk = 0, rst = 0, frame_valid = 0;
    logic [ROWS*COLS*CELL_W-1:0] grid_in = '0;
    logic frame_ready, busy, lcd_rst_n_out, lcd_bl_out, lcd_dc_out, lcd_clk_out, lcd_data_out, lcd_cs_n_out;
    logic [15:0] pal [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
        16'h8410, 16'hFC00, 16'h8000, 16'h0400, 16'h0010, 16'h8010, 16'h0410, 16'hC618
    };
    logic [8:0] exp_q [$];
    logic [8:0] dec_q [$];
    int n_checks = 0, n_pass = 0, n_acc = 0, bitc = 0;
    logic prev_rst = 0, prev_sck = 0, prev_mosi = 0;
    logic [7:0] shreg = '0;

    lcd_grid_streamer #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_PX(PX), .CLK_DIV(1),
                        .RST_HOLD(4), .RST_WAIT(4)) dut (
        .clk(clk), .rst(rst), .grid_in(grid_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .lcd_rst_n_out(lcd_rst_n_out),
        .lcd_bl_out(lcd_bl_out), .lcd_dc_out(lcd_dc_out), .lcd_clk_out(lcd_clk_out),
        .lcd_data_out(lcd_data_out), .lcd_cs_n_out(lcd_cs_n_out));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    function automatic logic [19:0] pack(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic push_init();
        exp_q.push_back(9'h011); exp_q.push_back(9'h03A); exp_q.push_back(9'h155);
        exp_q.push_back(9'h036); exp_q.push_back(9'h100); exp_q.push_back(9'h029);
    endtask

    task automatic push_frame(input logic [19:0] g);
        logic [15:0] wl, hl, c;
        logic [4:0] code;
        wl = 16'(W - 1);
        hl = 16'(H - 1);
        exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back({1'b1, wl[15:8]}); exp_q.push_back({1'b1, wl[7:0]});
        exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
        exp_q.push_back({1'b1, hl[15:8]}); exp_q.push_back({1'b1, hl[7:0]});
        exp_q.push_back(9'h02C);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                code = g[((y / PX) * COLS + x / PX) * CELL_W +: CELL_W];
                c = pal[code & 5'h0F];
`ifdef GRID_LINES_EN
                if (x % PX == 0 || y % PX == 0) c = 16'h8410;
`endif
                exp_q.push_back({1'b1, c[15:8]});
                exp_q.push_back({1'b1, c[7:0]});
            end
    endtask

    // Single compare process: SPI decode, scoreboard, handshake model.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            bitc = 0;
            prev_rst = 0;
        end else begin
            if (!prev_rst) push_init();
            prev_rst = 1;
            if (frame_valid && frame_ready) begin
                n_acc++;
                push_frame(grid_in);
            end
            check("busy_vs_ready", busy, !frame_ready);
            if (lcd_clk_out && !prev_sck && !lcd_cs_n_out) begin
                check("mosi_setup", lcd_data_out, prev_mosi);
                shreg = {shreg[6:0], lcd_data_out};
                bitc++;
                if (bitc == 8) begin
                    dec_q.push_back({lcd_dc_out, shreg});
                    bitc = 0;
                    if (exp_q.size() == 0) check("extra_byte", 0, 1);
                    else check("byte", {lcd_dc_out, shreg}, exp_q.pop_front());
                end
            end
            if (lcd_cs_n_out) bitc = 0;
        end
        prev_sck = lcd_clk_out;
        prev_mosi = lcd_data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (!(frame_ready && exp_q.size() == 0) && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check(name, i < 5000, 1);
    endtask

    task automatic release_reset(input string name);
        int lows = 0;
        int b;
        b = dec_q.size();
        tick();
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_rst_n_out) break;
            lows++;
        end
        check({name, "_rst_low_cycles"}, lows, 4);
        wait_done({name, "_init_timeout"});
        check({name, "_init_len"}, dec_q.size() - b, 6);
        check({name, "_init_first"}, dec_q[b], 9'h011);
        check({name, "_init_colmod"}, dec_q[b+2], 9'h155);
        check({name, "_init_last"}, dec_q[b+5], 9'h029);
        check({name, "_ready"}, frame_ready, 1);
        check({name, "_bl"}, lcd_bl_out, 1);
    endtask

    task automatic send_frame(input logic [19:0] g);
        tick();
        grid_in = g;
        frame_valid = 1;
        tick();
        frame_valid = 0;
        check("ready_drops", frame_ready, 0);
        check("busy_rises", busy, 1);
    endtask

    initial begin
        int b, acc0, i;
        repeat (3) tick();
        check("rst_lcd_rst_n", lcd_rst_n_out, 0);
        check("rst_bl", lcd_bl_out, 0);
        check("rst_dc", lcd_dc_out, 0);
        check("rst_sck", lcd_clk_out, 0);
        check("rst_mosi", lcd_data_out, 0);
        check("rst_cs_n", lcd_cs_n_out, 1);
        check("rst_ready", frame_ready, 0);
        check("rst_busy", busy, 1);
        release_reset("t1");

        b = dec_q.size();
        send_frame(pack(0, 1, 2, 3));
        wait_done("t2_timeout");
        check("t2_len", dec_q.size() - b, 43);
        check("t2_caset_lo", dec_q[b+4], 9'h103);
        check("t2_raset_lo", dec_q[b+9], 9'h103);
        check("t2_ramwr", dec_q[b+10], 9'h02C);
        check("t2_px2_hi", dec_q[b+15], P2H);
        check("t2_px2_lo", dec_q[b+16], P2L);
        check("t2_px8_hi", dec_q[b+27], P8H);
        check("t2_px8_lo", dec_q[b+28], P8L);
        check("t2_last_hi", dec_q[b+41], 9'h100);
        check("t2_last_lo", dec_q[b+42], 9'h11F);
        check("t2_busy_low", busy, 0);

        b = dec_q.size();
        acc0 = n_acc;
        tick();
        grid_in = pack(4, 5, 6, 7);
        frame_valid = 1;
        for (i = 0; i < 5000 && n_acc < acc0 + 2; i++) begin
            tick();
            grid_in = 20'($urandom);
        end
        frame_valid = 0;
        for (i = 0; i < 5000 && !(frame_ready && exp_q.size() == 0); i++) begin
            tick();
            grid_in = 20'($urandom);
        end
        check("t3_timeout", i < 5000, 1);
        check("t3_frames", n_acc - acc0, 2);
        check("t3_len", dec_q.size() - b, 86);

        b = dec_q.size();
        send_frame(pack(1, 2, 3, 4));
        for (i = 0; i < 5000 && dec_q.size() < b + 20; i++) tick();
        check("t4_reach_stream", i < 5000, 1);
        rst = 0;
        tick();
        check("t4_cs_n", lcd_cs_n_out, 1);
        check("t4_lcd_rst_n", lcd_rst_n_out, 0);
        check("t4_sck", lcd_clk_out, 0);
        check("t4_bl", lcd_bl_out, 0);
        check("t4_busy", busy, 1);
        release_reset("t4");

        b = dec_q.size();
        send_frame(pack(31, 31, 31, 31));
        wait_done("t5_timeout");
        check("t5_len", dec_q.size() - b, 43);
        check("t5_px0_hi", dec_q[b+11], F0H);
        check("t5_px0_lo", dec_q[b+12], F0L);
        check("t5_px5_hi", dec_q[b+21], 9'h1C6);
        check("t5_px5_lo", dec_q[b+22], 9'h118);

        b = dec_q.size();
        send_frame(pack(19, 31, 5, 10));
        wait_done("t6_timeout");
        check("t6_len", dec_q.size() - b, 43);
        check("t6_px5_hi", dec_q[b+21], 9'h100);
        check("t6_px5_lo", dec_q[b+22], 9'h11F);
        check("t6_cmd_dc", dec_q[b+5], 9'h02B);

        repeat (40) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
